// File: rtl/memory_access.sv
// Memory-access pipeline stage: drives a request/response data bus and extracts load data.
// Optional MEM_MISALIGN_CHECK_EN suppresses misaligned requests and flags them instead.
package memory_access_pkg;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemSize;
    logic       MemUnsigned;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [63:0] alu;
    logic [63:0] rs2;
    logic        valid;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic        valid;
    logic [63:0] result;
    logic        misalign;
  } memory_data_t;

endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          stalled,
  output logic          dreq_valid,
  output logic [63:0]   dreq_addr,
  output logic [2:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [63:0]   dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [63:0]   dresp_data,
  output memory_data_t  dataM_nxt,
  output logic          mem_wait
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] hold_data;
  logic [2:0]  offset;
  logic [63:0] load_shift;
  logic [63:0] load_ext;
  logic [7:0]  size_mask;
  logic        mem_op;
  logic        misalign;
  logic        issue;
  logic        done;

  assign offset = dataE.alu[2:0];
  assign mem_op = dataE.valid & (dataE.ctl.MemRead | dataE.ctl.MemWrite);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    unique case (dataE.ctl.MemSize)
      2'd0: misalign = 1'b0;
      2'd1: misalign = offset[0];
      2'd2: misalign = (offset[1:0] != 2'b00);
      2'd3: misalign = (offset != 3'b000);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign issue = mem_op & ~misalign;

  // Request fields come straight from dataE, which upstream holds while mem_wait is high.
  always_comb begin
    size_mask = 8'h00;
    unique case (dataE.ctl.MemSize)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
    endcase
  end

  assign dreq_addr   = issue ? dataE.alu : '0;
  assign dreq_size   = issue ? {1'b0, dataE.ctl.MemSize} : '0;
  assign dreq_strobe = (issue & dataE.ctl.MemWrite) ? (size_mask << offset) : '0;
  assign dreq_data   = issue ? (dataE.rs2 << {offset, 3'b000}) : '0;

  assign load_shift = dresp_data >> {offset, 3'b000};

  always_comb begin
    load_ext = load_shift;
    unique case (dataE.ctl.MemSize)
      2'd0: load_ext = dataE.ctl.MemUnsigned ? {56'd0, load_shift[7:0]}
                                             : {{56{load_shift[7]}}, load_shift[7:0]};
      2'd1: load_ext = dataE.ctl.MemUnsigned ? {48'd0, load_shift[15:0]}
                                             : {{48{load_shift[15]}}, load_shift[15:0]};
      2'd2: load_ext = dataE.ctl.MemUnsigned ? {32'd0, load_shift[31:0]}
                                             : {{32{load_shift[31]}}, load_shift[31:0]};
      2'd3: load_ext = load_shift;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    dreq_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          dreq_valid = 1'b1;
          if (dresp_addr_ok & dresp_data_ok) done = 1'b1;
          else if (dresp_addr_ok)            state_nxt = DATA;
          else                               state_nxt = ADDR;
        end
      end
      ADDR: begin
        dreq_valid = 1'b1;
        if (dresp_addr_ok & dresp_data_ok) done = 1'b1;
        else if (dresp_addr_ok)            state_nxt = DATA;
      end
      DATA: begin
        if (dresp_data_ok) done = 1'b1;
      end
      HOLD: begin
        if (!stalled) state_nxt = IDLE;
      end
    endcase
    if (done) state_nxt = stalled ? HOLD : IDLE;
    // Reset is asynchronous, so the request is squashed combinationally as well.
    dreq_valid = dreq_valid & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (done & stalled) hold_data <= load_ext;
    end
  end

  assign mem_wait = issue & ~done & (state != HOLD);

  always_comb begin
    dataM_nxt          = '0;
    dataM_nxt.pc       = dataE.pc;
    dataM_nxt.ctl      = dataE.ctl;
    dataM_nxt.valid    = dataE.valid;
    dataM_nxt.misalign = mem_op & misalign;
    if (dataE.ctl.MemRead) dataM_nxt.result = (state == HOLD) ? hold_data : load_ext;
    else                   dataM_nxt.result = dataE.alu;
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: single-cycle vector table plus
// multi-cycle sequences for wait states, stall hold, reset mid-transaction and misalignment.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          stalled;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM_nxt;
  logic          mem_wait;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  memory_access dut (
    .clk          (clk),
    .reset        (reset),
    .dataE        (dataE),
    .stalled      (stalled),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .dataM_nxt    (dataM_nxt),
    .mem_wait     (mem_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic        v;
    logic [63:0] alu;
    logic [63:0] rs2;
    logic [63:0] resp;
    logic        e_valid;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    logic [63:0] e_result;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] alu, input logic [63:0] rs2, input logic v);
    dataE                 = '0;
    dataE.pc              = 64'h8000_0000 + alu;
    dataE.ctl.MemRead     = rd;
    dataE.ctl.MemWrite    = wr;
    dataE.ctl.MemSize     = sz;
    dataE.ctl.MemUnsigned = uns;
    dataE.alu             = alu;
    dataE.rs2             = rs2;
    dataE.valid           = v;
  endtask

  task automatic acks(input logic a, input logic d);
    dresp_addr_ok = a;
    dresp_data_ok = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waits;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 64'h1000_0003, 64'h0, 64'h0000_0000_8000_0000,
                 1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 64'h1000_0003, 64'h0, 64'h0000_0000_8000_0000,
                 1'b1, 8'h00, 64'h0, 64'h0000_0000_0000_0080};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 64'h1000_0006, 64'h1234, 64'h0,
                 1'b1, 8'hC0, 64'h1234_0000_0000_0000, 64'h1000_0006};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 64'h2000_0004, 64'h0, 64'h8765_4321_0000_0000,
                 1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 64'h2000_0004, 64'h0, 64'h8765_4321_0000_0000,
                 1'b1, 8'h00, 64'h0, 64'h0000_0000_8765_4321};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 64'h3000_0000, 64'h0, 64'hDEAD_BEEF_0123_4567,
                 1'b1, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 64'h3000_0008, 64'hAABB_CCDD_EEFF_0011, 64'h0,
                 1'b1, 8'hFF, 64'hAABB_CCDD_EEFF_0011, 64'h3000_0008};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 64'h4000_0007, 64'h5A, 64'h0,
                 1'b1, 8'h80, 64'h5A00_0000_0000_0000, 64'h4000_0007};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 64'h5000_0002, 64'h0, 64'h0000_0000_F00D_0000,
                 1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_F00D};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 64'h1234, 64'h99, 64'h0,
                 1'b0, 8'h00, 64'h0, 64'h1234};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 64'h5678, 64'h1111, 64'h0,
                 1'b0, 8'h00, 64'h0, 64'h5678};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 64'h6000_0006, 64'h0, 64'hBEEF_0000_0000_0000,
                 1'b1, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 64'h7000_0004, 64'hCAFE_BABE, 64'h0,
                 1'b1, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h7000_0004};

    // reset state
    reset = 1'b0;
    stalled = 1'b0;
    dresp_data = '0;
    acks(1'b0, 1'b0);
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 1'b0);
    #3;
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_mem_wait", {63'd0, mem_wait}, 64'd0);
    chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rst_addr", dreq_addr, 64'd0);
    chk("rst_result", dataM_nxt.result, 64'd0);
    chk("rst_misalign", {63'd0, dataM_nxt.misalign}, 64'd0);
    #9 reset = 1'b1;

    // single-cycle transactions completing in IDLE
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      set_op(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].alu, vecs[i].rs2, vecs[i].v);
      dresp_data = vecs[i].resp;
      acks(1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_dreq_valid", i), {63'd0, dreq_valid}, {63'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_addr", i), dreq_addr, vecs[i].e_valid ? vecs[i].alu : 64'd0);
      chk($sformatf("v%0d_size", i), {61'd0, dreq_size},
          vecs[i].e_valid ? {62'd0, vecs[i].sz} : 64'd0);
      chk($sformatf("v%0d_strobe", i), {56'd0, dreq_strobe}, {56'd0, vecs[i].e_strobe});
      chk($sformatf("v%0d_data", i), dreq_data, vecs[i].e_data);
      chk($sformatf("v%0d_result", i), dataM_nxt.result, vecs[i].e_result);
      chk($sformatf("v%0d_mem_wait", i), {63'd0, mem_wait}, 64'd0);
      chk($sformatf("v%0d_pc", i), dataM_nxt.pc, 64'h8000_0000 + vecs[i].alu);
    end

    // wait states: addr_ok low 3 cycles, then data_ok 2 cycles after addr_ok
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_op(1'b0, 1'b1, 2'd2, 1'b0, 64'h44, 64'hDEAD_BEEF, 1'b1);
      acks(i == 3, i == 5);
      @(negedge clk);
      if (mem_wait) waits++;
      chk($sformatf("ws%0d_mem_wait", i), {63'd0, mem_wait}, {63'd0, i < 5});
      chk($sformatf("ws%0d_dreq_valid", i), {63'd0, dreq_valid}, {63'd0, i <= 3});
      if (i <= 3) begin
        chk($sformatf("ws%0d_addr", i), dreq_addr, 64'h44);
        chk($sformatf("ws%0d_strobe", i), {56'd0, dreq_strobe}, 64'hF0);
        chk($sformatf("ws%0d_data", i), dreq_data, 64'hDEAD_BEEF_0000_0000);
      end
    end
    chk("ws_wait_cycles", 64'(waits), 64'd5);

    // done while stalled: hold result for 4 stalled cycles, release when stall drops
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h71, 64'h0, 1'b1);
    dresp_data = 64'h0000_0000_0000_9C00;
    acks(1'b1, 1'b1);
    stalled = 1'b1;
    @(negedge clk);
    chk("st0_mem_wait", {63'd0, mem_wait}, 64'd0);
    chk("st0_result", dataM_nxt.result, 64'hFFFF_FFFF_FFFF_FF9C);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      dresp_data = 64'h1234_5678_9ABC_DEF0;
      stalled = (i < 4);
      @(negedge clk);
      chk($sformatf("st%0d_dreq_valid", i), {63'd0, dreq_valid}, 64'd0);
      chk($sformatf("st%0d_mem_wait", i), {63'd0, mem_wait}, 64'd0);
      chk($sformatf("st%0d_result", i), dataM_nxt.result, 64'hFFFF_FFFF_FFFF_FF9C);
    end
    @(posedge clk); #1;
    acks(1'b0, 1'b0);
    @(negedge clk);
    chk("st_release_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    chk("st_release_mem_wait", {63'd0, mem_wait}, 64'd1);
    @(posedge clk); #1;
    acks(1'b1, 1'b1);
    @(negedge clk);
    chk("st_finish_mem_wait", {63'd0, mem_wait}, 64'd0);

    // reset while in DATA
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h60, 64'h0, 1'b1);
    dresp_data = 64'h1111;
    acks(1'b1, 1'b0);
    @(negedge clk);
    chk("rd_issue_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    @(posedge clk); #1;
    acks(1'b0, 1'b0);
    @(negedge clk);
    chk("rd_data_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rd_data_mem_wait", {63'd0, mem_wait}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rd_reset_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h77, 64'h0, 1'b1);
    dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    acks(1'b0, 1'b1);
    @(negedge clk);
    chk("rd_late_result", dataM_nxt.result, 64'h77);
    chk("rd_late_mem_wait", {63'd0, mem_wait}, 64'd0);
    chk("rd_late_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h80, 64'h0, 1'b1);
    acks(1'b0, 1'b0);
    @(negedge clk);
    chk("rd_idle_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    chk("rd_idle_mem_wait", {63'd0, mem_wait}, 64'd1);
    // now in ADDR: both acks together must complete
    @(posedge clk); #1;
    dresp_data = 64'h0BAD_F00D_CAFE_0001;
    acks(1'b1, 1'b1);
    @(negedge clk);
    chk("addr_both_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    chk("addr_both_mem_wait", {63'd0, mem_wait}, 64'd0);
    chk("addr_both_result", dataM_nxt.result, 64'h0BAD_F00D_CAFE_0001);
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 1'b0);
    acks(1'b0, 1'b0);
    @(negedge clk);
    chk("after_addr_dreq_valid", {63'd0, dreq_valid}, 64'd0);

    // misaligned word load
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 1'b1);
    acks(1'b0, 1'b0);
    @(negedge clk);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("mis_mem_wait", {63'd0, mem_wait}, 64'd0);
    chk("mis_flag", {63'd0, dataM_nxt.misalign}, 64'd1);
`else
    chk("mis_dreq_valid", {63'd0, dreq_valid}, 64'd1);
    chk("mis_mem_wait", {63'd0, mem_wait}, 64'd1);
    chk("mis_flag", {63'd0, dataM_nxt.misalign}, 64'd0);
    @(posedge clk); #1;
    acks(1'b1, 1'b1);
    @(negedge clk);
    chk("mis_done_mem_wait", {63'd0, mem_wait}, 64'd0);
`endif
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 1'b0);
    acks(1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
